pmod_serial_tx: RTL and testbench



---
 rtl/pmod_serial_tx.sv | 124 ++++++++++++
 tb/tb_pmod_serial_tx.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/pmod_serial_tx.sv
// Serial transmitter for the board-to-board PMOD link: byte in over valid/ready,
// framed LSB-first bit stream out with a mid-bit sampling clock and frame strobe.
module pmod_serial_tx #(
   parameter int unsigned CLKS_PER_BIT = 2,
   parameter bit          PARITY_EN    = 1'b0
) (
   input  logic       i_Clk,
   input  logic       i_Rst_L,
   input  logic       i_Valid,
   input  logic [7:0] i_Data,
   output logic       o_Ready,
   output logic       o_Done,
   output logic       o_PMOD_Data,
   output logic       o_PMOD_Clk,
   output logic       o_PMOD_Frame
);

   localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);
   localparam logic [CntW-1:0] CntHalf = CntW'(CLKS_PER_BIT / 2);

   localparam logic [2:0] StIdle   = 3'd0;
   localparam logic [2:0] StStart  = 3'd1;
   localparam logic [2:0] StData   = 3'd2;
   localparam logic [2:0] StParity = 3'd3;
   localparam logic [2:0] StStop   = 3'd4;

   logic [2:0]      state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [2:0]      idx_q, idx_d;
   logic [7:0]      shift_q, shift_d;
   logic            par_q, par_d;
   logic            bit_end;

   logic ready_q, ready_d;
   logic done_q, done_d;
   logic line_q, line_d;
   logic bclk_q, bclk_d;
   logic frame_q, frame_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      par_d   = par_q;
      bit_end = (cnt_q == CntLast);

      if (state_q == StIdle) begin
         if (i_Valid) begin
            state_d = StStart;
            cnt_d   = '0;
            idx_d   = '0;
            shift_d = i_Data;
            par_d   = ^i_Data;
         end
      end else begin
         cnt_d = bit_end ? '0 : cnt_q + 1'b1;
         if (bit_end) begin
            case (state_q)
               StStart:  state_d = StData;
               StData: begin
                  if (idx_q == 3'd7) begin
                     state_d = PARITY_EN ? StParity : StStop;
                  end else begin
                     idx_d   = idx_q + 1'b1;
                     shift_d = {1'b0, shift_q[7:1]};
                  end
               end
               StParity: state_d = StStop;
               StStop:   state_d = StIdle;
               default:  state_d = StIdle;
            endcase
         end
      end
   end

   // Outputs are decoded from next state so the registers track the current state exactly.
   always_comb begin
      case (state_d)
         StStart:  line_d = 1'b0;
         StData:   line_d = shift_d[0];
         StParity: line_d = par_d;
         default:  line_d = 1'b1;
      endcase
      bclk_d  = (state_d != StIdle) && (cnt_d >= CntHalf);
      frame_d = (state_d == StData) || (state_d == StParity);
      ready_d = (state_d == StIdle);
      done_d  = (state_d == StStop) && (cnt_d == CntLast);
   end

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         par_q   <= 1'b0;
         ready_q <= 1'b1;
         done_q  <= 1'b0;
         line_q  <= 1'b1;
         bclk_q  <= 1'b0;
         frame_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         par_q   <= par_d;
         ready_q <= ready_d;
         done_q  <= done_d;
         line_q  <= line_d;
         bclk_q  <= bclk_d;
         frame_q <= frame_d;
      end
   end

   assign o_Ready      = ready_q;
   assign o_Done       = done_q;
   assign o_PMOD_Data  = line_q;
   assign o_PMOD_Clk   = bclk_q;
   assign o_PMOD_Frame = frame_q;

endmodule

// File: tb/tb_pmod_serial_tx.sv
// Directed bench for pmod_serial_tx: a default instance (2 clks/bit, no parity) and a
// parity instance (4 clks/bit) checked against hand-built frame vectors.
module tb_pmod_serial_tx;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       v0 = 1'b0;
   logic       v1 = 1'b0;
   logic [7:0] din = 8'h00;

   logic r0, d0, l0, c0, f0;
   logic r1, d1, l1, c1, f1;

   bit cur = 1'b0;
   logic o_ready, o_done, o_line, o_clk, o_frame;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   pmod_serial_tx #(.CLKS_PER_BIT(2), .PARITY_EN(1'b0)) dut0 (
      .i_Clk(clk), .i_Rst_L(rst_n), .i_Valid(v0), .i_Data(din),
      .o_Ready(r0), .o_Done(d0), .o_PMOD_Data(l0), .o_PMOD_Clk(c0), .o_PMOD_Frame(f0)
   );

   pmod_serial_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1'b1)) dut1 (
      .i_Clk(clk), .i_Rst_L(rst_n), .i_Valid(v1), .i_Data(din),
      .o_Ready(r1), .o_Done(d1), .o_PMOD_Data(l1), .o_PMOD_Clk(c1), .o_PMOD_Frame(f1)
   );

   assign o_ready = cur ? r1 : r0;
   assign o_done  = cur ? d1 : d0;
   assign o_line  = cur ? l1 : l0;
   assign o_clk   = cur ? c1 : c0;
   assign o_frame = cur ? f1 : f0;

   typedef struct {
      bit          sel;
      logic [7:0]  data;
      int          nbits;
      logic [10:0] exp_bits;
   } vec_t;

   vec_t vecs[7];

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
   endtask

   task automatic set_valid(input bit sel, input logic val);
      if (sel) v1 = val;
      else v0 = val;
   endtask

   // Present a byte at a negedge; returns just after the acceptance edge with valid dropped.
   task automatic start_frame(input bit sel, input logic [7:0] data);
      cur = sel;
      @(negedge clk);
      din = data;
      set_valid(sel, 1'b1);
      check("ready_before_accept", int'(o_ready), 1);
      @(posedge clk);
      #1 set_valid(sel, 1'b0);
   endtask

   // Samples cycles A+1..A+F then the idle cycle A+F+1; caller has just passed edge A.
   task automatic run_frame(input string name, input bit sel, input int nbits,
                            input logic [10:0] exp);
      int          cpb;
      int          flen;
      int          done_at;
      int          ready_low;
      int          frame_hi;
      int          errs;
      int          ph;
      logic [10:0] bits;
      logic        prev;
      cpb       = sel ? 4 : 2;
      flen      = nbits * cpb;
      done_at   = 0;
      ready_low = 0;
      frame_hi  = 0;
      errs      = 0;
      bits      = '0;
      prev      = 1'b0;
      for (int n = 1; n <= flen; n++) begin
         @(negedge clk);
         ph = (n - 1) % cpb;
         if (o_clk !== ((ph >= cpb / 2) ? 1'b1 : 1'b0)) errs++;
         if (ph == cpb / 2) bits[(n - 1) / cpb] = o_line;
         if (ph > 0 && o_line !== prev) errs++;
         prev = o_line;
         if (o_done === 1'b1) begin
            if (done_at != 0) errs++;
            done_at = n;
         end
         if (o_ready === 1'b0) ready_low++;
         if (o_frame === 1'b1) frame_hi++;
      end
      check({name, "_bits"}, int'(bits), int'(exp));
      check({name, "_done_at"}, done_at, flen);
      check({name, "_ready_low"}, ready_low, flen);
      check({name, "_frame_hi"}, frame_hi, (nbits - 2) * cpb);
      check({name, "_glitches"}, errs, 0);
      @(negedge clk);
      check({name, "_idle_after"}, int'({o_ready, o_line, o_clk, o_frame, o_done}), 'b11000);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{1'b0, 8'hA5, 10, {1'b1, 8'hA5, 1'b0}};
      vecs[1] = '{1'b0, 8'h00, 10, {1'b1, 8'h00, 1'b0}};
      vecs[2] = '{1'b0, 8'hFF, 10, {1'b1, 8'hFF, 1'b0}};
      vecs[3] = '{1'b1, 8'h07, 11, {1'b1, 1'b1, 8'h07, 1'b0}};
      vecs[4] = '{1'b1, 8'h03, 11, {1'b1, 1'b0, 8'h03, 1'b0}};
      vecs[5] = '{1'b1, 8'h80, 11, {1'b1, 1'b1, 8'h80, 1'b0}};
      vecs[6] = '{1'b1, 8'hFF, 11, {1'b1, 1'b0, 8'hFF, 1'b0}};

      // Reset held with valid high; release together with valid still asserted.
      cur  = 1'b0;
      din  = 8'hA5;
      v0   = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("reset_idle", int'({o_ready, o_line, o_clk, o_frame, o_done}), 'b11000);
      end
      rst_n = 1'b1;
      @(posedge clk);
      #1 v0 = 1'b0;
      run_frame("rst_release", 1'b0, 10, {1'b1, 8'hA5, 1'b0});

      for (int i = 0; i < 7; i++) begin
         start_frame(vecs[i].sel, vecs[i].data);
         run_frame($sformatf("vec%0d", i), vecs[i].sel, vecs[i].nbits, vecs[i].exp_bits);
      end

      // Back-to-back with valid held: one idle cycle between frames.
      cur = 1'b0;
      @(negedge clk);
      din = 8'h01;
      v0  = 1'b1;
      @(posedge clk);
      #1 din = 8'hFF;
      run_frame("b2b_first", 1'b0, 10, {1'b1, 8'h01, 1'b0});
      run_frame("b2b_second", 1'b0, 10, {1'b1, 8'hFF, 1'b0});
      v0 = 1'b0;

      // Data and valid changed mid-frame must not disturb the latched byte.
      start_frame(1'b0, 8'h3C);
      fork
         begin
            repeat (5) @(posedge clk);
            #1;
            din = 8'hC3;
            v0  = 1'b1;
         end
      join_none
      run_frame("midchange", 1'b0, 10, {1'b1, 8'h3C, 1'b0});
      run_frame("midchange_next", 1'b0, 10, {1'b1, 8'hC3, 1'b0});
      v0 = 1'b0;

      // Reset during data bit 4 (cycles A+11..A+12 at two clocks per bit).
      start_frame(1'b0, 8'h96);
      repeat (11) @(negedge clk);
      check("pre_reset_in_data", int'(o_frame), 1);
      #1 rst_n = 1'b0;
      #1 check("reset_async", int'({o_ready, o_line, o_clk, o_frame, o_done}), 'b11000);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("reset_hold", int'({o_ready, o_line, o_clk, o_frame, o_done}), 'b11000);
      end
      rst_n = 1'b1;
      @(negedge clk);
      check("post_reset_no_done", int'(o_done), 0);
      start_frame(1'b0, 8'h55);
      run_frame("after_reset", 1'b0, 10, {1'b1, 8'h55, 1'b0});

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
